// File: rtl/uart_receive.sv
// 8N1 oversampling receiver that assembles fixed-length packets into a parallel buffer.
// A packet becomes visible only when it is complete; partial packets time out or abort on a framing error.
module uart_receive #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned BYTES        = 12,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in,
  output logic [BYTES-1:0][7:0] rsp_buf,
  output logic                  rsp_valid,
  output logic                  frame_err,
  output logic                  timeout,
  output logic                  busy
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdleMax = TIMEOUT_BITS * CLKS_PER_BIT - 1;
  localparam int unsigned IdleW   = $clog2(IdleMax + 1);
  localparam int unsigned IdxW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CntW-1:0]  HalfM1   = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  FullM1   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleMax);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BYTES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                r_state, w_state_d;
  logic                  r_sync1, r_rx, r_rx_prev;
  logic [CntW-1:0]       r_clk_cnt, w_clk_cnt_d;
  logic [2:0]            r_bit_cnt, w_bit_cnt_d;
  logic [7:0]            r_shift, w_shift_d;
  logic [BYTES-1:0][7:0] r_shadow, w_shadow_d;
  logic [IdxW-1:0]       r_byte_idx, w_byte_idx_d;
  logic [IdleW-1:0]      r_idle_cnt, w_idle_cnt_d;
  logic [BYTES-1:0][7:0] r_rsp_buf, w_rsp_buf_d;
  logic                  r_rsp_valid, w_rsp_valid_d;
  logic                  r_frame_err, w_frame_err_d;
  logic                  r_timeout, w_timeout_d;
  logic                  w_fall;

  // Requiring a high-to-low transition means a held-low break cannot retrigger after a frame error.
  assign w_fall = r_rx_prev & ~r_rx;

  always_comb begin
    w_state_d     = r_state;
    w_clk_cnt_d   = r_clk_cnt;
    w_bit_cnt_d   = r_bit_cnt;
    w_shift_d     = r_shift;
    w_shadow_d    = r_shadow;
    w_byte_idx_d  = r_byte_idx;
    w_idle_cnt_d  = '0;
    w_rsp_buf_d   = r_rsp_buf;
    w_rsp_valid_d = 1'b0;
    w_frame_err_d = 1'b0;
    w_timeout_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_d   = StStart;
          w_clk_cnt_d = '0;
          w_bit_cnt_d = '0;
        end else if (r_byte_idx != '0) begin
          if (r_idle_cnt == IdleLast) begin
            w_byte_idx_d = '0;
            w_timeout_d  = 1'b1;
          end else begin
            w_idle_cnt_d = r_idle_cnt + 1'b1;
          end
        end
      end
      StStart: begin
        if (r_clk_cnt == HalfM1) begin
          w_clk_cnt_d = '0;
          w_state_d   = r_rx ? StIdle : StData;
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_clk_cnt == FullM1) begin
          w_clk_cnt_d            = '0;
          w_shift_d[r_bit_cnt]   = r_rx;
          w_bit_cnt_d            = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_d = StStop;
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StStop: begin
        if (r_clk_cnt == FullM1) begin
          w_clk_cnt_d = '0;
          w_state_d   = StIdle;
          if (r_rx) begin
            w_shadow_d[r_byte_idx] = r_shift;
            if (r_byte_idx == IdxLast) begin
              w_rsp_buf_d   = w_shadow_d;
              w_rsp_valid_d = 1'b1;
              w_byte_idx_d  = '0;
            end else begin
              w_byte_idx_d = r_byte_idx + 1'b1;
            end
          end else begin
            w_frame_err_d = 1'b1;
            w_byte_idx_d  = '0;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_rx        <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= StIdle;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_shadow    <= '0;
      r_byte_idx  <= '0;
      r_idle_cnt  <= '0;
      r_rsp_buf   <= '0;
      r_rsp_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sync1     <= data_in;
      r_rx        <= r_sync1;
      r_rx_prev   <= r_rx;
      r_state     <= w_state_d;
      r_clk_cnt   <= w_clk_cnt_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_shadow    <= w_shadow_d;
      r_byte_idx  <= w_byte_idx_d;
      r_idle_cnt  <= w_idle_cnt_d;
      r_rsp_buf   <= w_rsp_buf_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_frame_err <= w_frame_err_d;
      r_timeout   <= w_timeout_d;
    end
  end

  assign rsp_buf   = r_rsp_buf;
  assign rsp_valid = r_rsp_valid;
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;
  assign busy      = (r_state != StIdle) || (r_byte_idx != '0);

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: full packets, glitch, framing error, timeout, mid-frame reset.
module tb_uart_receive;

  localparam int C = 16;
  localparam int N = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              data_in = 1'b1;
  logic [N-1:0][7:0] rsp_buf;
  logic              rsp_valid, frame_err, timeout, busy;

  uart_receive #(
    .CLKS_PER_BIT(C),
    .BYTES       (N),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .rsp_buf  (rsp_buf),
    .rsp_valid(rsp_valid),
    .frame_err(frame_err),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int n_valid = 0, n_ferr = 0, n_to = 0, n_multi = 0;
  int valid_cyc = 0, to_cyc = 0, last_start = 0;

  always @(negedge clk) begin
    if (rsp_valid) begin n_valid++; valid_cyc = cyc; end
    if (frame_err) n_ferr++;
    if (timeout) begin n_to++; to_cyc = cyc; end
    if ((32'(rsp_valid) + 32'(frame_err) + 32'(timeout)) > 1) n_multi++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    data_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      tick(C);
    end
    data_in = stop_bit;
    tick(C);
    data_in = 1'b1;
  endtask

  task automatic send_pkt(input logic [N*8-1:0] pkt);
    for (int i = 0; i < N; i++) send_byte(pkt[i*8 +: 8], 1'b1);
  endtask

  function automatic logic [N*8-1:0] ramp(input logic [7:0] base);
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  function automatic logic [N*8-1:0] fill(input logic [7:0] b);
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_v, base_f, base_t, lat;

    // Reset and idle
    tick(5);
    check_eq("reset_buf", rsp_buf, '0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_pulses", {rsp_valid, frame_err, timeout}, 0);
    rst_n = 1'b1;
    tick(1000);
    check_eq("idle_buf", rsp_buf, '0);
    check_eq("idle_pulses", n_valid + n_ferr + n_to, 0);
    check_eq("idle_busy", busy, 0);

    // Full packet 0x00..0x0B
    base_v = n_valid;
    send_pkt(ramp(8'h00));
    tick(10);
    check_eq("pkt_valid_cnt", n_valid - base_v, 1);
    lat = valid_cyc - last_start;
    check_eq("pkt_latency_window", (lat >= 150 && lat <= 156), 1);
    check_eq("pkt_buf", rsp_buf, ramp(8'h00));
    check_eq("pkt_busy", busy, 0);

    // Glitch rejection
    base_v = n_valid; base_f = n_ferr; base_t = n_to;
    data_in = 1'b0;
    tick(4);
    data_in = 1'b1;
    tick(40);
    check_eq("glitch_busy", busy, 0);
    check_eq("glitch_pulses", (n_valid - base_v) + (n_ferr - base_f) + (n_to - base_t), 0);
    send_pkt(ramp(8'h10));
    tick(10);
    check_eq("glitch_pkt_cnt", n_valid - base_v, 1);
    check_eq("glitch_pkt_buf", rsp_buf, ramp(8'h10));

    // Framing error mid-packet
    base_v = n_valid; base_f = n_ferr;
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 1'b1);
    send_byte(8'hA5, 1'b0);
    tick(2 * C);
    check_eq("ferr_cnt", n_ferr - base_f, 1);
    check_eq("ferr_buf_held", rsp_buf, ramp(8'h10));
    check_eq("ferr_busy", busy, 0);
    send_pkt(fill(8'hF0));
    tick(10);
    check_eq("ferr_valid_cnt", n_valid - base_v, 1);
    check_eq("ferr_pkt_buf", rsp_buf, fill(8'hF0));

    // Idle timeout discards partial packet
    base_v = n_valid; base_t = n_to;
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b1);
    check_eq("to_busy_partial", busy, 1);
    tick(300);
    check_eq("to_not_early", n_to - base_t, 0);
    tick(30);
    check_eq("to_cnt", n_to - base_t, 1);
    lat = to_cyc - last_start;
    check_eq("to_timing_window", (lat >= 473 && lat <= 477), 1);
    check_eq("to_busy_after", busy, 0);
    send_pkt(fill(8'h3C));
    tick(10);
    check_eq("to_valid_cnt", n_valid - base_v, 1);
    check_eq("to_pkt_buf", rsp_buf, fill(8'h3C));
    check_eq("to_no_extra", n_to - base_t, 1);

    // Reset during bit 4 of byte 7
    base_v = n_valid; base_f = n_ferr; base_t = n_to;
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i), 1'b1);
    data_in = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      data_in = 1'(8'h5A >> i);
      tick(C);
    end
    data_in = 1'b1;
    tick(C / 2);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_buf", rsp_buf, '0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_pulses", {rsp_valid, frame_err, timeout}, 0);
    tick(3);
    data_in = 1'b1;
    rst_n = 1'b1;
    tick(20);
    check_eq("mrst_no_pulse", (n_valid - base_v) + (n_ferr - base_f) + (n_to - base_t), 0);
    send_pkt(ramp(8'h90));
    tick(10);
    check_eq("mrst_valid_cnt", n_valid - base_v, 1);
    check_eq("mrst_pkt_buf", rsp_buf, ramp(8'h90));

    check_eq("pulse_exclusive", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
